// File: rtl/shift_operand_sweeper.sv
// shift_operand_sweeper
//
// Upstream stimulus stage for a shift cell under test. A start pulse walks
// every (A,B) operand pair in A-major order, presenting each pair on a_o/b_o
// with valid_o high until the downstream capture stage takes it (ready_i).
// Each A group is preceded by a settle gap with valid_o low so the shift cell
// can settle on the new A value before any pair is captured. A single pass
// ends with a one-cycle done_o pulse.
//
// Build option:
//   SWEEP_SIGNED_B_EN  when defined, B is swept in two's-complement order
//                      (most negative first, most positive last) for the
//                      signed-B shift cell. Undefined: plain unsigned order.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst      in   1        asynchronous, active-high reset
//   start    in   1        begin a sweep; only looked at while idle
//   ready_i  in   1        downstream accepts the current pair
//   a_o      out  WIDTH_A  A operand to the shift cell
//   b_o      out  WIDTH_B  B (shift amount) operand to the shift cell
//   valid_o  out  1        a_o/b_o are stable and form a valid pair
//   busy_o   out  1        sweep in progress
//   done_o   out  1        one-cycle pulse after the last pair transfers

module shift_operand_sweeper #(
  parameter int WIDTH_A     = 2,
  parameter int WIDTH_B     = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ready_i,
  output logic [WIDTH_A-1:0] a_o,
  output logic [WIDTH_B-1:0] b_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o
);

  // Counter widths sized so the terminal value always fits; a width of 1 is
  // kept for degenerate settings so no zero-width vector appears.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [WIDTH_A-1:0] A_LAST = '1;

  // Both orders step B by +1 with natural wrap; only the starting point and
  // the final value differ. Signed order starts at the sign bit alone
  // (most negative) and ends on its complement (most positive).
`ifdef SWEEP_SIGNED_B_EN
  localparam logic [WIDTH_B-1:0] B_FIRST = WIDTH_B'(1) << (WIDTH_B - 1);
  localparam logic [WIDTH_B-1:0] B_LAST  = ~B_FIRST;
`else
  localparam logic [WIDTH_B-1:0] B_FIRST = '0;
  localparam logic [WIDTH_B-1:0] B_LAST  = '1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    DRIVE,
    DONE
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic          hold_met;
  logic          transfer;

  // The hold counter saturates at its terminal value, so equality is enough
  // to say the minimum hold time has been met and a stalled pair stays ready
  // to go the moment ready_i returns.
  assign hold_met = (hold_cnt == HOLD_LAST);
  assign transfer = (state == DRIVE) && hold_met && ready_i;

  // Whole sweep sequencer. All outputs are registered and updated on the same
  // edge as the state change so valid_o, a_o and b_o always move together.
  // In DRIVE nothing changes on the operand bus until a transfer, which is
  // what keeps a stalled pair stable for as long as ready_i stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_o      <= '0;
      b_o      <= B_FIRST;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_o      <= '0;
            b_o      <= B_FIRST;
            busy_o   <= 1'b1;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            if (GAP_CYCLES == 0) begin
              state   <= DRIVE;
              valid_o <= 1'b1;
            end else begin
              state   <= GAP;
              valid_o <= 1'b0;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            hold_cnt <= '0;
            valid_o  <= 1'b1;
            state    <= DRIVE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        DRIVE: begin
          if (transfer) begin
            hold_cnt <= '0;
            if (b_o != B_LAST) begin
              b_o <= b_o + WIDTH_B'(1);
            end else if (a_o != A_LAST) begin
              a_o <= a_o + WIDTH_A'(1);
              b_o <= B_FIRST;
              if (GAP_CYCLES == 0) begin
                valid_o <= 1'b1;
              end else begin
                valid_o <= 1'b0;
                gap_cnt <= '0;
                state   <= GAP;
              end
            end else begin
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state   <= DONE;
            end
          end else if (!hold_met) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
